// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, FSM states, ALU ops, decoder.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef enum logic [2:0] {
    K_ALU_R,
    K_ALU_I,
    K_LOAD,
    K_STORE,
    K_BRANCH,
    K_ECALL,
    K_ILLEGAL
  } kind_e;

  typedef struct packed {
    kind_e   kind;
    alu_op_e alu_op;
  } dec_t;

  // Classify an instruction word; anything outside the supported subset is K_ILLEGAL.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.kind   = K_ILLEGAL;
    d.alu_op = ALU_ADD;
    if (ir == ECALL) begin
      d.kind = K_ECALL;
    end else begin
      case (ir[6:0])
        OP_R: begin
          if (ir[31:25] == F7_BASE) begin
            case (ir[14:12])
              F3_ADD_SUB: begin d.kind = K_ALU_R; d.alu_op = ALU_ADD; end
              F3_SLT:     begin d.kind = K_ALU_R; d.alu_op = ALU_SLT; end
              F3_OR:      begin d.kind = K_ALU_R; d.alu_op = ALU_OR;  end
              F3_AND:     begin d.kind = K_ALU_R; d.alu_op = ALU_AND; end
              default:    d.kind = K_ILLEGAL;
            endcase
          end else if (ir[31:25] == F7_SUB && ir[14:12] == F3_ADD_SUB) begin
            d.kind   = K_ALU_R;
            d.alu_op = ALU_SUB;
          end
        end
        OP_IMM:    if (ir[14:12] == F3_ADD_SUB) d.kind = K_ALU_I;
        OP_LOAD:   if (ir[14:12] == F3_WORD)    d.kind = K_LOAD;
        OP_STORE:  if (ir[14:12] == F3_WORD)    d.kind = K_STORE;
        OP_BRANCH: if (ir[14:12] == F3_BEQ)     d.kind = K_BRANCH;
        default:   d.kind = K_ILLEGAL;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: NREG x XLEN, two async reads, one sync write, x0 hardwired to zero.
module cpu_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr1,
  input  logic [IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]  rdata1,
  output logic [XLEN-1:0]  rdata2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Next register contents; writes to x0 are dropped.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer over one shared memory port.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            halted,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out
);

  localparam int unsigned RIDX_W = $clog2(NREG);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] mdr_q, mdr_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d;
  logic            illegal_q, illegal_d;

  dec_t            dec;
  logic [XLEN-1:0] imm_c;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] branch_tgt;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;
  logic            mem_req_c, mem_we_c;
  logic [XLEN-1:0] mem_addr_c;

  assign dec        = decode(ir_q);
  assign pc_plus4   = pc_q + XLEN'(4);
  assign branch_tgt = pc_q + imm_q;

  cpu_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (ir_q[7 +: RIDX_W]),
    .wdata  (rf_wdata),
    .raddr1 (ir_q[15 +: RIDX_W]),
    .raddr2 (ir_q[20 +: RIDX_W]),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // Immediate generation, sign-extended to XLEN by instruction format.
  always_comb begin
    imm_c = '0;
    case (dec.kind)
      K_ALU_I, K_LOAD: imm_c = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
      K_STORE:         imm_c = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      K_BRANCH:        imm_c = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                                ir_q[11:8], 1'b0};
      default:         imm_c = '0;
    endcase
  end

  // ALU: register operand for R-type, immediate otherwise; address calc uses ADD.
  always_comb begin
    alu_b   = (dec.kind == K_ALU_R) ? b_q : imm_q;
    alu_res = '0;
    case (dec.alu_op)
      ALU_ADD: alu_res = a_q + alu_b;
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_SLT: alu_res = XLEN'($signed(a_q) < $signed(alu_b));
      default: alu_res = '0;
    endcase
  end

  // Sequencer next-state, datapath register updates and memory port drive.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    alu_out_d  = alu_out_q;
    illegal_d  = illegal_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    mem_addr_c = pc_q;
    rf_we      = 1'b0;
    rf_wdata   = alu_out_q;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_d    = 32'(mem_rdata);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_rdata1;
        b_d   = rf_rdata2;
        imm_d = imm_c;
        if (dec.kind == K_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (dec.kind)
          K_ALU_R, K_ALU_I: begin
            alu_out_d = alu_res;
            state_d   = S_WB;
          end
          K_LOAD, K_STORE: begin
            alu_out_d = alu_res;
            state_d   = S_MEM;
          end
          K_BRANCH: begin
            pc_d    = (a_q == b_q) ? branch_tgt : pc_plus4;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        mem_addr_c = alu_out_q;
        mem_we_c   = (dec.kind == K_STORE);
        if (mem_ready) begin
          if (dec.kind == K_STORE) begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = (dec.kind == K_LOAD) ? mdr_q : alu_out_q;
        pc_d     = pc_plus4;
        state_d  = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_out_q <= alu_out_d;
      illegal_q <= illegal_d;
    end
  end

  // Request is killed immediately by reset so an in-flight handshake is abandoned.
  assign mem_req   = mem_req_c & ~reset;
  assign mem_we    = mem_we_c & ~reset;
  assign mem_addr  = {mem_addr_c[XLEN-1:2], 2'b00};
  assign mem_wdata = b_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign pc_out    = pc_q;

endmodule
